// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Operands are registered into the ALU; the result returns with a one-cycle done pulse.
module alu_arbiter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [2:0]       op0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    input  logic [2:0]       op1,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_control,
    input  logic [WIDTH-1:0] alu_result,
    output logic [1:0]       gnt,
    output logic [1:0]       done,
    output logic [WIDTH-1:0] result,
    output logic             err,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [2:0]       alu_control_q, alu_control_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [1:0]       gnt_q, gnt_d;
    logic [1:0]       done_q, done_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;
    logic             owner_q, owner_d;
    logic             illegal_q, illegal_d;
    logic             ptr_q, ptr_d;
    logic             win;
    logic [2:0]       win_op;

    // Codes 100, 101 and 110 have no ALU function.
    function automatic logic op_illegal(input logic [2:0] op);
        return (op == 3'b100) || (op == 3'b101) || (op == 3'b110);
    endfunction

    always_comb begin
        state_d       = state_q;
        alu_a_d       = alu_a_q;
        alu_b_d       = alu_b_q;
        alu_control_d = alu_control_q;
        result_d      = result_q;
        gnt_d         = 2'b00;
        done_d        = 2'b00;
        err_d         = err_q;
        busy_d        = 1'b0;
        owner_d       = owner_q;
        illegal_d     = illegal_q;
        ptr_d         = ptr_q;
        win           = 1'b0;
        win_op        = op0;

        case (state_q)
            IDLE: begin
                if (req != 2'b00) begin
                    // Single requester wins outright; on contention the pointer decides.
                    win           = (req == 2'b11) ? ptr_q : req[1];
                    win_op        = win ? op1 : op0;
                    alu_a_d       = win ? a1 : a0;
                    alu_b_d       = win ? b1 : b0;
                    alu_control_d = win_op;
                    owner_d       = win;
                    illegal_d     = op_illegal(win_op);
                    gnt_d         = win ? 2'b10 : 2'b01;
                    busy_d        = 1'b1;
                    state_d       = EXEC;
                end
            end
            EXEC: begin
                result_d = illegal_q ? '0 : alu_result;
                err_d    = illegal_q;
                done_d   = owner_q ? 2'b10 : 2'b01;
                busy_d   = 1'b1;
                state_d  = RESP;
            end
            RESP: begin
                ptr_d   = ~owner_q;
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            alu_control_q <= 3'b000;
            result_q      <= '0;
            gnt_q         <= 2'b00;
            done_q        <= 2'b00;
            err_q         <= 1'b0;
            busy_q        <= 1'b0;
            owner_q       <= 1'b0;
            illegal_q     <= 1'b0;
            ptr_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            alu_control_q <= alu_control_d;
            result_q      <= result_d;
            gnt_q         <= gnt_d;
            done_q        <= done_d;
            err_q         <= err_d;
            busy_q        <= busy_d;
            owner_q       <= owner_d;
            illegal_q     <= illegal_d;
            ptr_q         <= ptr_d;
        end
    end

    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_control = alu_control_q;
    assign result      = result_q;
    assign gnt         = gnt_q;
    assign done        = done_q;
    assign err         = err_q;
    assign busy        = busy_q;

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single combinational `alu` (A, B, control → result) between two requesters, e.g. the multi-cycle CPU control path and an address/branch helper.
- Arbitrates round-robin and registers the operands driven into the ALU.
- Captures the ALU result into a register and returns it to the winning requester with a one-cycle done pulse.
- Sits between the requesters and the `alu` instance; it is the only driver of the ALU inputs.

Parameters:
- WIDTH, 32, operand/result width; must match the ALU datapath.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req  in  2  per-requester request; bit i = requester i
- a0, b0  in  WIDTH each  requester 0 operands
- op0  in  3  requester 0 ALU control code
- a1, b1  in  WIDTH each  requester 1 operands
- op1  in  3  requester 1 ALU control code
- alu_a, alu_b  out  WIDTH  registered operands to ALU A/B
- alu_control  out  3  registered control to ALU
- alu_result  in  WIDTH  ALU combinational result
- gnt  out  2  one-hot, one-cycle grant (EXEC cycle)
- done  out  2  one-hot, one-cycle completion (RESP cycle)
- result  out  WIDTH  registered result; valid while done≠0, held afterwards
- err  out  1  high with done when the served opcode was illegal
- busy  out  1  high in EXEC and RESP

Behaviour:
- Legal control codes: 000 add, 001 sub, 010 nor, 011 and, 111 slt (signed less-than, result 0 or 1). Codes 100, 101, 110 are illegal.
- FSM states: IDLE, EXEC, RESP. All outputs are registered.
- Reset: state=IDLE; alu_a, alu_b, alu_control, result = 0; gnt, done = 00; err, busy = 0; priority pointer = requester 0.
- IDLE, req=00: stay IDLE. Outputs: gnt=00, done=00, busy=0. alu_* and result hold their values.
- IDLE, req≠00: winner is the set bit if only one bit is set. If both are set, the winner is the pointer's requester.
  - Latch winner's a/b/op into alu_a/alu_b/alu_control; record owner and illegal flag.
  - Next state EXEC.
- EXEC: gnt[owner]=1, busy=1, ALU inputs stable.
  - At the closing edge, result ← alu_result, or 0 if the opcode is illegal.
  - err ← illegal flag. Next state RESP.
- RESP: done[owner]=1, busy=1, result and err valid.
  - At the closing edge, pointer ← other requester (1−owner). Next state IDLE.
- err is cleared when leaving RESP.
- Latency: req sampled at edge E → gnt high in cycle after E → done high in cycle after E+1. Throughput is one operation per 3 cycles.
- req is ignored outside IDLE. A requester whose req is still high at the IDLE edge after its done is treated as issuing a new request.
- Requesters must hold operands stable only until the sampling edge; they are latched there.
- Fairness: with both reqs continuously high, grants alternate 0,1,0,1… from reset. No requester waits more than one foreign operation.
- Single requester repeatedly requesting gets back-to-back service. The pointer still flips after each service, harmlessly.
- Width rules: add/sub wrap modulo 2^WIDTH with no carry/overflow output. The result register is exactly WIDTH bits.
- Reset mid-operation (rst high in EXEC or RESP): return to IDLE next cycle. No done is issued for the aborted operation. Pointer resets to 0 and result clears to 0.
- rst has priority over all other inputs in the same cycle.

Test Plan:
- Reset: assert rst 2 cycles → gnt=00, done=00, result=0, err=0, busy=0, alu_control=000.
- Single request: req=01, a0=123123, b0=234234, op0=000 → gnt=01 next cycle, done=01 the cycle after, result=357357 (0x000573ED), err=0.
  - Repeat with op0=001 → result=0xFFFE4DF9.
- Contention/round-robin: req=11 held for 4 operations. Requester 0 has a=0x0101, b=0x1010, op=010; requester 1 has a=0xABCD, b=0xEFAB, op=011.
  - Required order: done=01 (0xFFFFEEEE), 10 (0x0000AB89), 01, 10.
  - Each done is exactly 3 cycles apart.
- slt and illegal opcode:
  - op1=111, a1=123123, b1=322325 → result=1.
  - op1=111, a1=0xFFFFFFFF, b1=1 → result=1 (signed).
  - op1=101 → done=10, err=1, result=0.
- Reset mid-op: req=01, assert rst during the EXEC cycle → no done pulse at all. Following req=10 is served with gnt=10 (pointer at 0, only requester 1 requesting).
- req ignored while busy: req=01 then raise req[1] during EXEC and drop it in RESP → requester 1 never granted. done=01 only.
